// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: operand/control bundle between the register file, control unit and the multiply/divide unit.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic mthi;
  logic mtlo;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, mthi, mtlo, input busy, done, hi, lo);
  modport slave (input start, op, a, b, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO.
// MDU_FAST_MUL_EN: MULT/MULTU use a combinational multiplier and finish in one cycle.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset_n,
  mdu_hilo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_q;
  logic is_div;
  logic sa;
  logic sb;
  logic b_zero;
  logic signed_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] trial;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
  assign signed_op = ~bus.op[0];
  assign mag_a = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend} for divide
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
  assign shl = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial = shl - {1'b0, m};
  assign acc_nx = is_div ? (trial[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                         : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                         : {sum, acc[WIDTH-1:1]};
  assign prod_s = (sa ^ sb) ? -acc : acc;
  assign quo = acc[WIDTH-1:0];
  assign rem = acc[2*WIDTH-1:WIDTH];
  // a zero divisor yields all-ones quotient and the untouched dividend as remainder
  assign hi_fix = is_div ? (b_zero ? a_q : (sa ? -rem : rem)) : prod_s[2*WIDTH-1:WIDTH];
  assign lo_fix = is_div ? (b_zero ? {WIDTH{1'b1}} : ((sa ^ sb) ? -quo : quo)) : prod_s[WIDTH-1:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      a_q <= '0;
      is_div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      b_zero <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            m <= bus.op[1] ? mag_b : mag_a;
            a_q <= bus.a;
            is_div <= bus.op[1];
            sa <= signed_op & bus.a[WIDTH-1];
            sb <= signed_op & bus.b[WIDTH-1];
            b_zero <= bus.b == '0;
            cnt <= '0;
            bus.busy <= 1'b1;
`ifdef MDU_FAST_MUL_EN
            acc <= bus.op[1] ? {{WIDTH{1'b0}}, mag_a} : prod;
            state <= bus.op[1] ? CALC : FIX;
`else
            acc <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            state <= CALC;
`endif
          end else begin
            if (bus.mthi) bus.hi <= bus.a;
            if (bus.mtlo) bus.lo <= bus.a;
          end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          bus.hi <= hi_fix;
          bus.lo <= lo_fix;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and random checks of mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk;
  logic reset_n;
  int tests;
  int fails;
  bit chk_en;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic m_busy;
  logic m_done;
  int m_left;
  logic [63:0] res;
  mdu_hilo_if #(.WIDTH(32)) bus ();
  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // {hi, lo} an operation must leave behind, from plain integer arithmetic
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) begin
      p = sx * sy;
      return p;
    end
    if (o == 2'd1) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = longint'(x) / longint'(y);
      r = longint'(x) % longint'(y);
    end
    return {r[31:0], q[31:0]};
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_hi <= '0;
      m_lo <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= res[63:32];
          m_lo <= res[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (bus.start) begin
        res <= ref_op(bus.op, bus.a, bus.b);
        m_left <= (!bus.op[1] && FAST) ? 1 : 33;
        m_busy <= 1'b1;
      end else begin
        if (bus.mthi) m_hi <= bus.a;
        if (bus.mtlo) m_lo <= bus.a;
      end
    end
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
    end
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int nb;
    int nd;
    nb = 0;
    nd = 0;
    @(negedge clk);
    #1 bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      nb += int'(bus.busy);
      nd += int'(bus.done);
      #1 bus.start = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.op = 2'($urandom);
    end
    check("busy_cycles", 64'(nb), (!o[1] && FAST) ? 64'd1 : 64'd33);
    check("done_pulses", 64'(nd), 64'd1);
    check("lit_hi", 64'(bus.hi), 64'(eh));
    check("lit_lo", 64'(bus.lo), 64'(el));
  endtask
  initial begin
    tests = 0;
    fails = 0;
    chk_en = 1'b0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(2'd3, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    @(negedge clk);
    #1 bus.mthi = 1'b1;
    bus.a = 32'hAAAA0000;
    @(negedge clk);
    check("mthi_hi", 64'(bus.hi), 64'hAAAA0000);
    check("mthi_done", 64'(bus.done), 64'd0);
    #1 bus.mthi = 1'b0;
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.a = 32'd10;
    bus.b = 32'd3;
    @(negedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 bus.mthi = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 32'h5555;
    @(negedge clk);
    #1 bus.mthi = 1'b0;
    bus.start = 1'b0;
    repeat (35) @(negedge clk);
    check("busy_div_lo", 64'(bus.lo), 64'd3);
    check("busy_div_hi", 64'(bus.hi), 64'd1);
    #1 bus.start = 1'b1;
    bus.op = 2'd1;
    bus.a = 32'd5;
    bus.b = 32'd6;
    @(negedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    run_op(2'd1, 32'd5, 32'd6, 32'd0, 32'd30);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1 reset_n = ($urandom % 700) != 0;
      bus.start = ($urandom % 6) == 0;
      bus.op = 2'($urandom);
      bus.a = pick();
      bus.b = pick();
      bus.mthi = ($urandom % 4) == 0;
      bus.mtlo = ($urandom % 4) == 0;
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    repeat (40) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
